// File: rtl/store_align_unit_if.sv
// Store-path bundle between the core store datapath, store_align_unit and the data-memory write port.
// slave = the align unit; master = the core / memory side that drives requests and responses.
interface store_align_unit_if;
    // Core side: st_valid/func3/st_addr/st_data are held until st_ready is seen high.
    // Memory side: mem_req/mem_addr/mem_wdata/mem_wstrb are held until mem_gnt.
    // mem_ack is honoured only while the unit waits for it.
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  func3;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        st_done;
    logic        st_err;
    logic [1:0]  st_err_cause;

    modport slave (
        input  st_valid, func3, st_addr, st_data, mem_gnt, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
               st_done, st_err, st_err_cause
    );

    modport master (
        output st_valid, func3, st_addr, st_data, mem_gnt, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
               st_done, st_err, st_err_cause
    );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment and single-outstanding data-memory write engine (SB/SH/SW).
// Optional: define STORE_MISALIGN_TRAP_EN to trap misaligned SH/SW with cause 01.
module store_align_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    store_align_unit_if.slave bus,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        REPORT   = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;
    localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic        st_ready_q;
    logic        mem_req_q;
    logic        st_done_q;
    logic        st_err_q;
    logic [1:0]  cause_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [7:0]  cnt_q;

    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [1:0]  cause_d;
    logic        err_d;

    // Lane replication instead of a shifter: the strobe picks which copy lands in memory.
    always_comb begin
        strb_d  = 4'b0000;
        wdata_d = 32'h0000_0000;
        cause_d = CAUSE_NONE;
        case (bus.func3)
            3'b000: begin
                strb_d  = 4'b0001 << bus.st_addr[1:0];
                wdata_d = {4{bus.st_data[7:0]}};
            end
            3'b001: begin
                strb_d  = 4'b0011 << {bus.st_addr[1], 1'b0};
                wdata_d = {2{bus.st_data[15:0]}};
`ifdef STORE_MISALIGN_TRAP_EN
                if (bus.st_addr[0]) cause_d = CAUSE_MISALIGN;
`endif
            end
            3'b010: begin
                strb_d  = 4'b1111;
                wdata_d = bus.st_data;
`ifdef STORE_MISALIGN_TRAP_EN
                if (bus.st_addr[1:0] != 2'b00) cause_d = CAUSE_MISALIGN;
`endif
            end
            default: cause_d = CAUSE_ILLEGAL;
        endcase
    end

    assign err_d = (cause_d != CAUSE_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            cause_q     <= CAUSE_NONE;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            cnt_q       <= 8'd0;
        end else begin
            st_done_q <= 1'b0;
            st_err_q  <= 1'b0;
            cause_q   <= CAUSE_NONE;
            case (state_q)
                IDLE: begin
                    if (bus.st_valid) begin
                        st_ready_q <= 1'b0;
                        if (err_d) begin
                            // Rejected stores never touch the memory-side registers.
                            state_q  <= REPORT;
                            st_err_q <= 1'b1;
                            cause_q  <= cause_d;
                        end else begin
                            state_q     <= ISSUE;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {bus.st_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= strb_d;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_gnt) begin
                        state_q   <= WAIT_ACK;
                        mem_req_q <= 1'b0;
                        cnt_q     <= 8'd0;
                    end
                end
                WAIT_ACK: begin
                    if (bus.mem_ack) begin
                        state_q   <= REPORT;
                        st_done_q <= 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q  <= REPORT;
                        st_err_q <= 1'b1;
                        cause_q  <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                REPORT: begin
                    state_q    <= IDLE;
                    st_ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= IDLE;
                    st_ready_q <= 1'b1;
                    mem_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.st_ready     = st_ready_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.st_done      = st_done_q;
    assign bus.st_err       = st_err_q;
    assign bus.st_err_cause = cause_q;
    assign dbg_state_o      = state_q;

    a_req_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
        mem_req_q == (state_q == ISSUE));
    a_ready_only_in_idle: assert property (@(posedge clk) disable iff (!rst_n)
        st_ready_q == (state_q == IDLE));
    a_done_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(st_done_q && st_err_q));
endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit built with TIMEOUT=4.
module tb_store_align_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    store_align_unit_if bus ();

    store_align_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_valid = 1'b0;
        bus.func3    = 3'b000;
        bus.st_addr  = 32'h0;
        bus.st_data  = 32'h0;
        bus.mem_gnt  = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    // Presents one store for the current cycle, lets the edge accept it, then drops st_valid.
    task automatic send_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        bus.st_valid = 1'b1;
        bus.func3    = f3;
        bus.st_addr  = addr;
        bus.st_data  = data;
        tick();
        bus.st_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #23;
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.st_ready); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
        total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
        total++; if (bus.mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got=%b exp=0000", bus.mem_wstrb); end
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.st_done); end
        total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.st_err); end
        total++; if (bus.st_err_cause !== 2'b00) begin bad++; $display("FAIL rst_cause got=%b exp=00", bus.st_err_cause); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sb_best_case();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL sb_ready_T got=%b exp=1", bus.st_ready); end
        send_store(3'b000, 32'h0000_1003, 32'h0000_00A5);
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL sb_req got=%b exp=1", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", bus.mem_addr); end
        total++; if (bus.mem_wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b exp=1000", bus.mem_wstrb); end
        total++; if (bus.mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus.mem_wdata); end
        total++; if (bus.st_ready !== 1'b0) begin bad++; $display("FAIL sb_busy got=%b exp=0", bus.st_ready); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sb_req_drop got=%b exp=0", bus.mem_req); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL sb_done got=%b exp=1", bus.st_done); end
        total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL sb_noerr got=%b exp=0", bus.st_err); end
        tick();
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL sb_done_pulse got=%b exp=0", bus.st_done); end
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL sb_ready_T4 got=%b exp=1", bus.st_ready); end
    endtask

    task automatic test_sh_delayed_gnt();
        send_store(3'b001, 32'h0000_2002, 32'h1234_BEEF);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL sh_req_%0d got=%b exp=1", i, bus.mem_req); end
            total++; if (bus.mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL sh_addr_%0d got=%h exp=00002000", i, bus.mem_addr); end
            total++; if (bus.mem_wstrb !== 4'b1100) begin bad++; $display("FAIL sh_wstrb_%0d got=%b exp=1100", i, bus.mem_wstrb); end
            total++; if (bus.mem_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata_%0d got=%h exp=beefbeef", i, bus.mem_wdata); end
            bus.mem_gnt = (i == 3);
            bus.mem_ack = (i >= 2);
            tick();
        end
        bus.mem_gnt = 1'b0;
        bus.mem_ack = 1'b0;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sh_req_drop got=%b exp=0", bus.mem_req); end
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL sh_early_done got=%b exp=0", bus.st_done); end
        tick();
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL sh_gnt_ack_ignored got=%b exp=0", bus.st_done); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL sh_wait_state got=%0d exp=2", dbg_state); end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL sh_done got=%b exp=1", bus.st_done); end
        tick();
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL sh_one_done got=%b exp=0", bus.st_done); end
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL sh_ready got=%b exp=1", bus.st_ready); end
    endtask

    task automatic test_sw_misaligned();
        send_store(3'b010, 32'h0000_3001, 32'h89AB_CDEF);
`ifdef STORE_MISALIGN_TRAP_EN
        total++; if (bus.st_err !== 1'b1) begin bad++; $display("FAIL swm_err got=%b exp=1", bus.st_err); end
        total++; if (bus.st_err_cause !== 2'b01) begin bad++; $display("FAIL swm_cause got=%b exp=01", bus.st_err_cause); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL swm_noreq got=%b exp=0", bus.mem_req); end
        tick();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL swm_ready got=%b exp=1", bus.st_ready); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL swm_noreq2 got=%b exp=0", bus.mem_req); end
`else
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL swm_req got=%b exp=1", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL swm_addr got=%h exp=00003000", bus.mem_addr); end
        total++; if (bus.mem_wstrb !== 4'b1111) begin bad++; $display("FAIL swm_wstrb got=%b exp=1111", bus.mem_wstrb); end
        total++; if (bus.mem_wdata !== 32'h89AB_CDEF) begin bad++; $display("FAIL swm_wdata got=%h exp=89abcdef", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL swm_done got=%b exp=1", bus.st_done); end
        total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL swm_noerr got=%b exp=0", bus.st_err); end
        tick();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL swm_ready got=%b exp=1", bus.st_ready); end
`endif
    endtask

    task automatic test_illegal_func3();
        logic [2:0] codes [2];
        codes[0] = 3'b011;
        codes[1] = 3'b111;
        for (int i = 0; i < 2; i++) begin
            send_store(codes[i], 32'h0000_0040, 32'hFFFF_FFFF);
            total++; if (bus.st_err !== 1'b1) begin bad++; $display("FAIL ill_err_%0d got=%b exp=1", i, bus.st_err); end
            total++; if (bus.st_err_cause !== 2'b11) begin bad++; $display("FAIL ill_cause_%0d got=%b exp=11", i, bus.st_err_cause); end
            total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL ill_noreq_%0d got=%b exp=0", i, bus.mem_req); end
            total++; if (bus.st_ready !== 1'b0) begin bad++; $display("FAIL ill_busy_%0d got=%b exp=0", i, bus.st_ready); end
            tick();
            total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL ill_ready_%0d got=%b exp=1", i, bus.st_ready); end
            total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL ill_pulse_%0d got=%b exp=0", i, bus.st_err); end
        end
    endtask

    task automatic test_timeout();
        send_store(3'b010, 32'h0000_4000, 32'hCAFE_F00D);
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL to_req got=%b exp=1", bus.mem_req); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.st_err !== 1'b0) begin bad++; $display("FAIL to_early_err_%0d got=%b exp=0", k, bus.st_err); end
            total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL to_wait_%0d got=%0d exp=2", k, dbg_state); end
            tick();
        end
        total++; if (bus.st_err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", bus.st_err); end
        total++; if (bus.st_err_cause !== 2'b10) begin bad++; $display("FAIL to_cause got=%b exp=10", bus.st_err_cause); end
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL to_nodone got=%b exp=0", bus.st_done); end
        bus.mem_ack = 1'b1;
        tick();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL to_ready got=%b exp=1", bus.st_ready); end
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL to_late_ack1 got=%b exp=0", bus.st_done); end
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b0 || bus.st_err !== 1'b0) begin bad++; $display("FAIL to_late_ack2 got=%b%b exp=00", bus.st_done, bus.st_err); end
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL to_idle got=%b exp=1", bus.st_ready); end
    endtask

    task automatic test_back_to_back();
        send_store(3'b000, 32'h0000_5001, 32'h0000_0077);
        total++; if (bus.mem_wstrb !== 4'b0010) begin bad++; $display("FAIL b2b_wstrb1 got=%b exp=0010", bus.mem_wstrb); end
        total++; if (bus.mem_wdata !== 32'h7777_7777) begin bad++; $display("FAIL b2b_wdata1 got=%h exp=77777777", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", bus.st_done); end
        total++; if (bus.st_ready !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", bus.st_ready); end
        bus.st_valid = 1'b1;
        bus.func3    = 3'b001;
        bus.st_addr  = 32'h0000_5000;
        bus.st_data  = 32'h0000_ABCD;
        tick();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.st_ready); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL b2b_valid_ignored got=%b exp=0", bus.mem_req); end
        total++; if (bus.st_done !== 1'b0) begin bad++; $display("FAIL b2b_done_pulse got=%b exp=0", bus.st_done); end
        tick();
        bus.st_valid = 1'b0;
        total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL b2b_req2 got=%b exp=1", bus.mem_req); end
        total++; if (bus.mem_addr !== 32'h0000_5000) begin bad++; $display("FAIL b2b_addr2 got=%h exp=00005000", bus.mem_addr); end
        total++; if (bus.mem_wstrb !== 4'b0011) begin bad++; $display("FAIL b2b_wstrb2 got=%b exp=0011", bus.mem_wstrb); end
        total++; if (bus.mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL b2b_wdata2 got=%h exp=abcdabcd", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", bus.st_done); end
        tick();
    endtask

    task automatic test_reset_mid();
        send_store(3'b010, 32'h0000_6000, 32'h1122_3344);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmi_req got=%b exp=0", bus.mem_req); end
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL rmi_ready got=%b exp=1", bus.st_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_store(3'b010, 32'h0000_6000, 32'h1122_3344);
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL rmw_wait got=%0d exp=2", dbg_state); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL rmw_ready got=%b exp=1", bus.st_ready); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rmw_state got=%0d exp=0", dbg_state); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmw_req got=%b exp=0", bus.mem_req); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        total++; if (bus.st_done !== 1'b0 || bus.st_err !== 1'b0) begin bad++; $display("FAIL rmw_no_report got=%b%b exp=00", bus.st_done, bus.st_err); end
        send_store(3'b000, 32'h0000_7002, 32'h0000_005A);
        total++; if (bus.mem_wstrb !== 4'b0100) begin bad++; $display("FAIL rmn_wstrb got=%b exp=0100", bus.mem_wstrb); end
        total++; if (bus.mem_wdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rmn_wdata got=%h exp=5a5a5a5a", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        total++; if (bus.st_done !== 1'b1) begin bad++; $display("FAIL rmn_done got=%b exp=1", bus.st_done); end
        tick();
        total++; if (bus.st_ready !== 1'b1) begin bad++; $display("FAIL rmn_ready got=%b exp=1", bus.st_ready); end
    endtask

    initial begin
        test_reset();
        test_sb_best_case();
        test_sh_delayed_gnt();
        test_sw_misaligned();
        test_illegal_func3();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the sequence finished");
        $fatal(1);
    end
endmodule

// File: doc/store_align_unit.md
# store_align_unit

Write-path counterpart of the load sign-extension logic: takes a store (SB/SH/SW) from the execute stage, generates the byte strobes and lane-replicated write data, and performs one data-memory write transaction over a req/gnt/ack handshake. It sits between the core's store datapath and the data-memory port. It holds exactly one store in flight and reports completion or error back to the core.

## Interface
- TIMEOUT, default 15: maximum cycles spent in WAIT_ACK before a bus timeout; legal range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request from core
- st_ready  out  1  unit can accept a store; high only in IDLE
- func3  in  3  store width: 000 SB, 001 SH, 010 SW; any other value is illegal
- st_addr  in  32  byte address of the store
- st_data  in  32  rs2 value
- mem_req  out  1  write request to data memory
- mem_gnt  in  1  memory accepted the request
- mem_addr  out  32  word address {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated write data
- mem_wstrb  out  4  byte enables, bit i = byte lane i
- mem_ack  in  1  write completed
- st_done  out  1  one-cycle pulse: store completed
- st_err  out  1  one-cycle pulse: store failed, nothing (or nothing acknowledged) written
- st_err_cause  out  2  valid with st_err: 01 misaligned, 10 timeout, 11 illegal func3

## Operation
- States: IDLE, ISSUE, WAIT_ACK, REPORT.
- IDLE: st_ready=1. On st_valid&&st_ready, register addr, strobe, data, and the error check; go to ISSUE, or to REPORT with error if the check fails.
- Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111.
- Data: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d. No shifter; the strobes select the lane.
- Illegal func3 -> REPORT, cause 11, no bus activity.
- Misaligned (SH with addr[0]=1; SW with addr[1:0]!=0) is handled per Configuration.
- ISSUE: mem_req=1 with mem_addr/mem_wdata/mem_wstrb stable until mem_gnt is sampled high; then go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK: mem_req=0. The counter increments each cycle. mem_ack=1 -> REPORT ok. Counter reaching TIMEOUT without ack -> REPORT, cause 10.
- REPORT: drive st_done or st_err (+cause) for exactly one cycle, then go to IDLE.
- mem_ack is sampled only in WAIT_ACK. An ack in the gnt cycle, in IDLE, or after a timeout is ignored.
- st_valid is ignored outside IDLE. The core holds the request until st_ready.

## Timing
- All outputs are registered. Reset values: st_ready=1 (IDLE), mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, st_done=0, st_err=0, st_err_cause=0.
- Best case: accept at T; mem_req high T+1 with gnt at T+1; ack at T+2; st_done at T+3; st_ready high at T+4.
- Error detected at accept: st_err at T+1, st_ready at T+2. No mem_req is ever raised.
- Timeout: st_err (cause 10) on the cycle after the TIMEOUT-th WAIT_ACK cycle without ack.
- Reset asserted mid-transaction: state returns to IDLE immediately and mem_req drops asynchronously. No done/err is reported for the aborted store.
- mem_wstrb/mem_wdata hold their last values outside ISSUE. Consumers qualify them with mem_req.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: a misaligned SH/SW goes to REPORT with cause 01 and no bus access.
- Not defined: no misalignment error. SH uses addr[1] only; SW writes the whole containing word (addr[1:0] ignored) with strobe 1111. Cause 01 is never produced.

## Test plan
- SB, addr=0x1003, data=0xA5 -> mem_addr=0x1000, mem_wstrb=1000, mem_wdata=0xA5A5A5A5; st_done at T+3 with gnt and ack at earliest.
- SH, addr=0x2002, data=0x1234BEEF, gnt delayed 3 cycles -> mem_req held 4 cycles with stable outputs; mem_wstrb=1100, mem_wdata=0xBEEFBEEF; one st_done.
- SW, addr=0x3001 -> with the macro: st_err, cause 01, mem_req never high. Without it: mem_addr=0x3000, mem_wstrb=1111, st_done.
- func3=011 -> st_err, cause 11 at T+1; no bus request; st_ready back at T+2.
- TIMEOUT=4 and ack never arrives -> st_err, cause 10 after 4 WAIT_ACK cycles. A late ack in IDLE produces no pulse.
- rst_n pulled low in WAIT_ACK -> mem_req=0 and st_ready=1 immediately. The next store after release completes normally.
